mult_writer: RTL and testbench

MULT_WRITER -- requirements
Module: mult_writer

---
 rtl/mult_writer_pkg.sv | 26 ++
 rtl/mult_writer.sv | 144 ++++++++++++++
 tb/tb_mult_writer.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/mult_writer_pkg.sv
// mult_writer_pkg
// Shared constants for the multiply/writeback unit and its register file:
// writeback mode codes, FSM state encoding and the shift-add iteration count.
// Optional feature macro used by mult_writer: MULT_WRITER_SIGNED_EN.
package mult_writer_pkg;

    localparam int ITER_COUNT = 32;
    localparam int CNT_W      = 6;

    localparam logic [1:0] MUL_NONE = 2'd0;
    localparam logic [1:0] MUL_LOAD = 2'd1;
    localparam logic [1:0] MUL_ACC  = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_WB   = 2'd2
    } state_t;

    // Two's-complement magnitude of a 32-bit value. 0x80000000 maps to
    // itself, which is the correct unsigned magnitude.
    function automatic logic [31:0] abs32(input logic [31:0] v);
        return v[31] ? (~v + 32'd1) : v;
    endfunction

endpackage

// File: rtl/mult_writer.sv
// mult_writer
// Sequential 32x32 radix-2 shift-add multiplier that hands a 64-bit product
// to the register file as a one-cycle writeback pulse (load or accumulate).
// Fixed latency: write_enable rises on the 33rd edge after the accepting edge.
//
// Ports:
//   clk, rst                  clock, asynchronous active-high reset
//   start, acc, is_signed     request, accumulate mode, signed operands
//   op_a, op_b                32-bit operands (sampled with start)
//   busy                      operation in flight (through the writeback cycle)
//   write_enable, mul         writeback pulse and mode (MUL_NONE/LOAD/ACC)
//   write_data_1/2            product low / high word, held between pulses
//
// Macro MULT_WRITER_SIGNED_EN: when defined, is_signed=1 multiplies operand
// magnitudes and negates the result if signs differ. Undefined: unsigned only.
module mult_writer
    import mult_writer_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic        acc,
    input  logic        is_signed,
    input  logic [31:0] op_a,
    input  logic [31:0] op_b,
    output logic        busy,
    output logic        write_enable,
    output logic [1:0]  mul,
    output logic [31:0] write_data_1,
    output logic [31:0] write_data_2
);

    state_t             r_state;
    state_t             w_next;
    logic [CNT_W-1:0]   r_cnt;
    logic [63:0]        r_mcand;
    logic [31:0]        r_mplier;
    logic [63:0]        r_prod;
    logic               r_acc;
    logic               r_busy;
    logic               r_we;
    logic [1:0]         r_mul;
    logic [31:0]        r_wd1;
    logic [31:0]        r_wd2;

    logic               w_accept;
    logic               w_last;
    logic [31:0]        w_a_mag;
    logic [31:0]        w_b_mag;
    logic [63:0]        w_result;

`ifdef MULT_WRITER_SIGNED_EN
    logic               r_neg;
    logic               w_neg;

    always_comb begin
        w_a_mag  = (is_signed && op_a[31]) ? abs32(op_a) : op_a;
        w_b_mag  = (is_signed && op_b[31]) ? abs32(op_b) : op_b;
        w_neg    = is_signed && (op_a[31] ^ op_b[31]);
        w_result = r_neg ? (~r_prod + 64'd1) : r_prod;
    end
`else
    always_comb begin
        w_a_mag  = op_a;
        w_b_mag  = op_b;
        w_result = r_prod;
    end
`endif

    // busy also covers the cycle the pulse is on the outputs, so a start
    // presented as WB drops back to IDLE is not taken.
    assign w_accept = (r_state == ST_IDLE) && start && !r_busy;
    assign w_last   = (r_cnt == CNT_W'(ITER_COUNT - 1));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= ST_IDLE;
        else     r_state <= w_next;
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE: if (w_accept) w_next = ST_RUN;
            ST_RUN:  if (w_last)   w_next = ST_WB;
            ST_WB:                 w_next = ST_IDLE;
            default:               w_next = ST_IDLE;
        endcase
    end

    // Shift-add datapath: one multiplier bit per RUN cycle, no early-out.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mcand  <= '0;
            r_mplier <= '0;
            r_prod   <= '0;
            r_cnt    <= '0;
            r_acc    <= 1'b0;
`ifdef MULT_WRITER_SIGNED_EN
            r_neg    <= 1'b0;
`endif
        end else if (w_accept) begin
            r_mcand  <= {32'd0, w_a_mag};
            r_mplier <= w_b_mag;
            r_prod   <= '0;
            r_cnt    <= '0;
            r_acc    <= acc;
`ifdef MULT_WRITER_SIGNED_EN
            r_neg    <= w_neg;
`endif
        end else if (r_state == ST_RUN) begin
            if (r_mplier[0]) r_prod <= r_prod + r_mcand;
            r_mcand  <= r_mcand << 1;
            r_mplier <= r_mplier >> 1;
            r_cnt    <= r_cnt + CNT_W'(1);
        end
    end

    // Registered outputs: the pulse is launched from the WB state, which puts
    // it on the 33rd edge after acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_busy <= 1'b0;
            r_we   <= 1'b0;
            r_mul  <= MUL_NONE;
            r_wd1  <= '0;
            r_wd2  <= '0;
        end else begin
            r_busy <= (w_next != ST_IDLE) || (r_state == ST_WB);
            r_we   <= (r_state == ST_WB);
            r_mul  <= (r_state == ST_WB) ? (r_acc ? MUL_ACC : MUL_LOAD) : MUL_NONE;
            if (r_state == ST_WB) begin
                r_wd1 <= w_result[31:0];
                r_wd2 <= w_result[63:32];
            end
        end
    end

    assign busy         = r_busy;
    assign write_enable = r_we;
    assign mul          = r_mul;
    assign write_data_1 = r_wd1;
    assign write_data_2 = r_wd2;

endmodule

// File: tb/tb_mult_writer.sv
module tb_mult_writer;
    import mult_writer_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        acc;
    logic        is_signed;
    logic [31:0] op_a;
    logic [31:0] op_b;
    logic        busy;
    logic        write_enable;
    logic [1:0]  mul;
    logic [31:0] write_data_1;
    logic [31:0] write_data_2;

    mult_writer dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .acc          (acc),
        .is_signed    (is_signed),
        .op_a         (op_a),
        .op_b         (op_b),
        .busy         (busy),
        .write_enable (write_enable),
        .mul          (mul),
        .write_data_1 (write_data_1),
        .write_data_2 (write_data_2)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [1:0]  mode;
        logic [63:0] prod;
        int          due;
    } exp_t;

    exp_t        sb[$];
    exp_t        e;
    int          n_tests = 0;
    int          n_fail  = 0;
    int          cyc     = 0;
    int          pulses  = 0;
    int          p0;
    logic [31:0] last_lo;
    logic [31:0] last_hi;
    logic [1:0]  last_mul;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic logic [63:0] model(input logic [31:0] a, input logic [31:0] b, input logic sg);
`ifdef MULT_WRITER_SIGNED_EN
        if (sg) return 64'($signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}));
`endif
        return {32'd0, a} * {32'd0, b};
    endfunction

    // Monitor: every pulse is matched against the scoreboard head.
    always @(negedge clk) begin
        if (!rst) begin
            if (write_enable) begin
                pulses++;
                last_lo  = write_data_1;
                last_hi  = write_data_2;
                last_mul = mul;
                if (sb.size() == 0) chk("unexpected_we", 64'd1, 64'd0);
                else begin
                    e = sb.pop_front();
                    chk("mul",     64'(mul),          64'(e.mode));
                    chk("wd1",     64'(write_data_1), 64'(e.prod[31:0]));
                    chk("wd2",     64'(write_data_2), 64'(e.prod[63:32]));
                    chk("latency", 64'(cyc),          64'(e.due));
                end
            end else begin
                chk("mul_idle", 64'(mul), 64'(MUL_NONE));
            end
        end
    end

    task automatic issue(input logic [31:0] a, input logic [31:0] b, input logic ac, input logic sg);
        exp_t x;
        int g;
        g = 0;
        @(negedge clk);
        while (busy && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (busy) chk("idle_timeout", 64'd1, 64'd0);
        start = 1'b1; op_a = a; op_b = b; acc = ac; is_signed = sg;
        x.mode = ac ? MUL_ACC : MUL_LOAD;
        x.prod = model(a, b, sg);
        x.due  = cyc + 34;
        sb.push_back(x);
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_pulse();
        int pp;
        int g;
        pp = pulses;
        g  = 0;
        while (pulses == pp && g < 60) begin
            @(negedge clk); #1;
            g++;
        end
        chk("pulse_timeout", 64'(pulses != pp), 64'd1);
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; acc = 1'b0; is_signed = 1'b0; op_a = '0; op_b = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_we",   64'(write_enable), 64'd0);
        chk("rst_mul",  64'(mul), 64'd0);
        chk("rst_wd1",  64'(write_data_1), 64'd0);
        chk("rst_wd2",  64'(write_data_2), 64'd0);
        rst = 1'b0;

        issue(32'd3, 32'd5, 1'b0, 1'b0);
        wait_pulse();
        chk("r27_wd1", 64'(last_lo), 64'd15);
        chk("r27_wd2", 64'(last_hi), 64'd0);
        chk("r27_mul", 64'(last_mul), 64'(MUL_LOAD));

        issue(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 1'b0);
        wait_pulse();
        chk("r28_wd2", 64'(last_hi), 64'hFFFF_FFFE);
        chk("r28_wd1", 64'(last_lo), 64'h0000_0001);

        issue(32'hFFFF_FFFE, 32'd3, 1'b0, 1'b1);
        wait_pulse();
`ifdef MULT_WRITER_SIGNED_EN
        chk("r29_wd2", 64'(last_hi), 64'hFFFF_FFFF);
        chk("r29_wd1", 64'(last_lo), 64'hFFFF_FFFA);
`else
        chk("uns_wd2", 64'(last_hi), 64'h0000_0002);
        chk("uns_wd1", 64'(last_lo), 64'hFFFF_FFFA);
`endif

        issue(32'd7, 32'd6, 1'b1, 1'b0);
        wait_pulse();
        chk("r30_mul", 64'(last_mul), 64'(MUL_ACC));
        chk("r30_wd1", 64'(last_lo), 64'd42);
        repeat (3) @(negedge clk);
        chk("hold_wd1", 64'(write_data_1), 64'd42);
        chk("hold_we",  64'(write_enable), 64'd0);

        // Second start during RUN must be ignored; busy holds until the pulse.
        issue(32'd100, 32'd200, 1'b0, 1'b0);
        p0 = pulses;
        repeat (3) @(negedge clk);
        start = 1'b1; op_a = 32'd9; op_b = 32'd9;
        @(negedge clk);
        start = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk); #1;
            if (write_enable) break;
            chk("busy_hold", 64'(busy), 64'd1);
        end
        repeat (40) @(negedge clk);
        chk("one_pulse", 64'(pulses - p0), 64'd1);

        // start presented in the pulse cycle (WB just returned to IDLE).
        issue(32'd11, 32'd13, 1'b0, 1'b0);
        wait_pulse();
        p0 = pulses;
        start = 1'b1; op_a = 32'd5; op_b = 32'd5;
        @(negedge clk);
        start = 1'b0;
        repeat (40) @(negedge clk);
        chk("wb_start_ign", 64'(pulses - p0), 64'd0);
        chk("wb_busy_low",  64'(busy), 64'd0);

        // Reset in the middle of RUN aborts without a pulse.
        issue(32'd123, 32'd456, 1'b0, 1'b0);
        repeat (9) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_we",   64'(write_enable), 64'd0);
        chk("abort_wd1",  64'(write_data_1), 64'd0);
        sb.delete();
        p0 = pulses;
        @(negedge clk);
        rst = 1'b0;
        repeat (40) @(negedge clk);
        chk("abort_nopulse", 64'(pulses - p0), 64'd0);

        for (int i = 0; i < 6; i++) begin
            issue($urandom, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
            wait_pulse();
        end
        issue(32'h8000_0000, 32'h8000_0000, 1'b0, 1'b1);
        wait_pulse();
        issue(32'h8000_0000, 32'd1, 1'b1, 1'b1);
        wait_pulse();

        repeat (2) @(negedge clk);
        chk("sb_empty", 64'(sb.size()), 64'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
